// File: rtl/vga_timing_gen_if.sv
// vga_if: raster timing bundle carried from vga_timing_gen to vga_out.
//   hcount, vcount : CNT_W-bit horizontal / vertical position
//   hsync, vsync   : sync levels (polarity chosen by the generator)
//   hblnk, vblnk   : blanking flags
// Modports: master drives the bundle (timing generator), slave consumes it.
interface vga_if #(
    parameter int CNT_W = 11
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk
    );

    modport slave (
        input hcount, vcount, hsync, vsync, hblnk, vblnk
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator with a run/stop controller that
// only stops on a frame boundary.
//   clk, rst     : clock and synchronous active-high reset
//   en           : run request (level)
//   pix_ce       : pixel clock enable; counters advance only when 1
//   vga          : vga_if master (hcount, vcount, hsync, vsync, hblnk, vblnk)
//   line_start   : one-clk strobe when hcount becomes 0 while running
//   frame_start  : one-clk strobe when (hcount,vcount) becomes (0,0) while running
//   frame_cnt    : number of frame starts, wraps 0xFFFF -> 0
//   busy         : controller not idle
//
// state      | meaning
// S_IDLE     | stopped, counters at (0,0), blanked, syncs inactive
// S_RUN      | raster running, en held high
// S_STOPPING | en dropped; keep scanning until the last pixel of the frame
module vga_timing_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1,
    parameter int CNT_W      = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pix_ce,
    vga_if.master       vga,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if ((longint'(H_TOTAL) - 1 >= (longint'(1) << CNT_W)) ||
            (longint'(V_TOTAL) - 1 >= (longint'(1) << CNT_W))) begin : g_width_chk
            $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
        end
    endgenerate

    // All boundaries pre-computed at CNT_W width so no runtime compare needs a carry bit.
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             at_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            hblnk_q       <= 1'b1;
            vblnk_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_cnt_d   = frame_cnt_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        at_end        = (hcount_q == H_LAST) && (vcount_q == V_LAST);

        case (state_q)
            S_IDLE: begin
                if (en && pix_ce) begin
                    state_d       = S_RUN;
                    hcount_d      = '0;
                    vcount_d      = '0;
                    line_start_d  = 1'b1;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                end
            end
            S_RUN, S_STOPPING: begin
                // en is sampled every clk; only the counters wait for pix_ce.
                if (state_q == S_RUN && !en) begin
                    state_d = S_STOPPING;
                end else if (state_q == S_STOPPING && en) begin
                    state_d = S_RUN;
                end
                if (pix_ce) begin
                    if (state_q == S_STOPPING && !en && at_end) begin
                        state_d  = S_IDLE;
                        hcount_d = '0;
                        vcount_d = '0;
                    end else if (hcount_q == H_LAST) begin
                        hcount_d     = '0;
                        line_start_d = 1'b1;
                        if (vcount_q == V_LAST) begin
                            vcount_d      = '0;
                            frame_start_d = 1'b1;
                            frame_cnt_d   = frame_cnt_q + 16'd1;
                        end else begin
                            vcount_d = vcount_q + 1'b1;
                        end
                    end else begin
                        hcount_d = hcount_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                hcount_d = '0;
                vcount_d = '0;
            end
        endcase

        // Levels are decoded from the next counter values so they register
        // alongside the counters and stay aligned with them.
        hblnk_d = (state_d == S_IDLE) || (hcount_d >= H_ACT);
        vblnk_d = (state_d == S_IDLE) || (vcount_d >= V_ACT);
        hsync_d = ((state_d != S_IDLE) && (hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST))
                  ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d = ((state_d != S_IDLE) && (vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST))
                  ? V_SYNC_POL : ~V_SYNC_POL;
    end

    assign vga.hcount  = hcount_q;
    assign vga.vcount  = vcount_q;
    assign vga.hsync   = hsync_q;
    assign vga.vsync   = vsync_q;
    assign vga.hblnk   = hblnk_q;
    assign vga.vblnk   = vblnk_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign busy        = (state_q != S_IDLE);

endmodule
